det_sequencer: RTL

Controller that sequences a registered-output serial sequence detector.
- Accepts a parallel word through a start/ready handshake.
- Clears the detector, then shifts the word into it one bit per clock.
- Collects the detector's match output with the correct one-cycle alignment.
- Reports match count and first-match bit index with a done pulse.
- Sits between a host register interface and the detector's in_ports, out_ports and reset pins.

---
 rtl/det_sequencer_if.sv | 25 ++
 rtl/det_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/det_sequencer_if.sv
// Host-side handshake and result bus of det_sequencer.
// master = host driving start/data_in, slave = the sequencer.
interface det_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] first_idx;
    logic             hit;

    modport master (
        output start, data_in,
        input  ready, busy, done, match_cnt, first_idx, hit
    );

    modport slave (
        input  start, data_in,
        output ready, busy, done, match_cnt, first_idx, hit
    );
endinterface

// File: rtl/det_sequencer.sv
// Sequences a registered serial pattern detector: clear, shift one word in, collect matches.
// Build option DET_SEQ_LSB_FIRST_EN shifts the word LSB first instead of MSB first.
//
// state   | meaning
// S_IDLE  | ready for a word; start captures data_in
// S_CLEAR | det_clr pulse to the detector
// S_SHIFT | WIDTH cycles of ser_out, bit counter 0..WIDTH-1
// S_DRAIN | collect the match for the last shifted bit
// S_DONE  | done pulse, results valid
module det_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    det_sequencer_if.slave  host,
    input  logic            det_match,
    output logic            ser_out,
    output logic            det_clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic             ser_out_q, ser_out_d;
    logic             det_clr_q, det_clr_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic             hit_q, hit_d;

    logic             sample_en;
    logic [CNT_W-1:0] sample_idx;
    logic             next_bit;
    logic [WIDTH-1:0] word_shifted;

`ifdef DET_SEQ_LSB_FIRST_EN
    assign next_bit     = word_q[0];
    assign word_shifted = {1'b0, word_q[WIDTH-1:1]};
`else
    assign next_bit     = word_q[WIDTH-1];
    assign word_shifted = {word_q[WIDTH-2:0], 1'b0};
`endif

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        bit_d      = bit_q;
        ser_out_d  = ser_out_q;
        det_clr_d  = 1'b0;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        first_d    = first_q;
        hit_d      = hit_q;
        sample_en  = 1'b0;
        sample_idx = '0;

        case (state_q)
            S_IDLE: begin
                if (host.start) begin
                    word_d    = host.data_in;
                    cnt_d     = '0;
                    first_d   = '0;
                    hit_d     = 1'b0;
                    state_d   = S_CLEAR;
                    det_clr_d = 1'b1;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    ser_out_d = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d   = S_SHIFT;
                bit_d     = '0;
                ser_out_d = next_bit;
                word_d    = word_shifted;
            end
            S_SHIFT: begin
                // detector output lags its input by one cycle
                if (bit_q != '0) begin
                    sample_en  = 1'b1;
                    sample_idx = bit_q - ONE;
                end
                if (bit_q == LAST_BIT) begin
                    state_d   = S_DRAIN;
                    ser_out_d = 1'b0;
                end else begin
                    bit_d     = bit_q + ONE;
                    ser_out_d = next_bit;
                    word_d    = word_shifted;
                end
            end
            S_DRAIN: begin
                sample_en  = 1'b1;
                sample_idx = LAST_BIT;
                state_d    = S_DONE;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                ser_out_d  = 1'b0;
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                bit_d   = '0;
            end
            default: begin
                state_d   = S_IDLE;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
                ser_out_d = 1'b0;
            end
        endcase

        if (sample_en && det_match) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + ONE;
            if (!hit_q) begin
                first_d = sample_idx;
                hit_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            bit_q     <= '0;
            ser_out_q <= 1'b0;
            det_clr_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            first_q   <= '0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            bit_q     <= bit_d;
            ser_out_q <= ser_out_d;
            det_clr_q <= det_clr_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            hit_q     <= hit_d;
        end
    end

    assign ser_out        = ser_out_q;
    assign det_clr        = det_clr_q;
    assign host.ready     = ready_q;
    assign host.busy      = busy_q;
    assign host.done      = done_q;
    assign host.match_cnt = cnt_q;
    assign host.first_idx = first_q;
    assign host.hit       = hit_q;

endmodule
